mc_ctrl: RTL and testbench

//  Multi-cycle control FSM for the 32-bit MIPS datapath. Decodes opcode/funct and sequences fetch, decode,

---
 rtl/mips_pkg.sv | 79 +++++++
 rtl/mc_decode.sv | 47 ++++
 rtl/mc_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, FSM states
// and the datapath select codes driven by mc_ctrl.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_OUT  = 2'b01;
    localparam logic [1:0] PC_JUMP = 2'b10;
    localparam logic [1:0] PC_RS   = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] MR_ALU = 2'b00;
    localparam logic [1:0] MR_MDR = 2'b01;
    localparam logic [1:0] MR_PC  = 2'b10;

    localparam logic [1:0] SB_RT   = 2'b00;
    localparam logic [1:0] SB_FOUR = 2'b01;
    localparam logic [1:0] SB_IMM  = 2'b10;
    localparam logic [1:0] SB_IMM4 = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_ILL
    } iclass_t;

    typedef struct packed {
        iclass_t    iclass;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
    } decode_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps {opcode, funct} to an instruction class,
// the ALU operation, the immediate-extension mode and an illegal flag.
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        dec.iclass = CL_ILL;
        dec.alu_op = ALU_ADD;
        dec.ext_op = EXT_SIGN;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin dec.iclass = CL_R; dec.alu_op = ALU_ADD; end
                    FN_SUB: begin dec.iclass = CL_R; dec.alu_op = ALU_SUB; end
                    FN_AND: begin dec.iclass = CL_R; dec.alu_op = ALU_AND; end
                    FN_OR:  begin dec.iclass = CL_R; dec.alu_op = ALU_OR;  end
                    FN_SLT: begin dec.iclass = CL_R; dec.alu_op = ALU_SLT; end
                    FN_JR:  dec.iclass = CL_JR;
                    default: dec.iclass = CL_ILL;
                endcase
            end
            OP_LW:   dec.iclass = CL_LW;
            OP_SW:   dec.iclass = CL_SW;
            OP_BEQ:  begin dec.iclass = CL_BEQ; dec.alu_op = ALU_SUB; end
            OP_BNE:  begin dec.iclass = CL_BNE; dec.alu_op = ALU_SUB; end
            OP_J:    dec.iclass = CL_J;
            OP_JAL:  dec.iclass = CL_JAL;
            OP_ADDI: begin dec.iclass = CL_I; dec.alu_op = ALU_ADD; end
            OP_SLTI: begin dec.iclass = CL_I; dec.alu_op = ALU_SLT; end
            OP_ANDI: begin dec.iclass = CL_I; dec.alu_op = ALU_AND; dec.ext_op = EXT_ZERO; end
            OP_ORI:  begin dec.iclass = CL_I; dec.alu_op = ALU_OR;  dec.ext_op = EXT_ZERO; end
            // lui relies on rs being $0, so add passes the shifted immediate through.
            OP_LUI:  begin dec.iclass = CL_I; dec.alu_op = ALU_ADD; dec.ext_op = EXT_LUI; end
            default: dec.iclass = CL_ILL;
        endcase
    end

    assign illegal = (dec.iclass == CL_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back, owns the
// memory handshake with timeout, the retired-instruction counter and the sticky trap.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             iord,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       ext_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t        state_q, state_n;
    decode_t       dec, dec_q;
    logic          illegal;
    logic          rst_q;
    logic [TW-1:0] wait_cnt;
    logic          timeout;
    logic          retire;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .dec     (dec),
        .illegal (illegal)
    );

    // rst_q keeps every output quiet for the cycle after reset, so an access cut short by
    // reset sees mem_req fall on the reset edge itself.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            rst_q     <= 1'b1;
            dec_q     <= '{iclass: CL_ILL, alu_op: ALU_ADD, ext_op: EXT_SIGN};
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            state_q <= state_n;
            rst_q   <= 1'b0;
            if (state_q == ST_DECODE)
                dec_q <= dec;
            if (!mem_req || mem_ready)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TW'(MEM_TIMEOUT - 1));
    assign retire  = !rst_q && (state_q != ST_FETCH) && (state_n == ST_FETCH);
    assign state   = state_q;
    assign trap    = (state_q == ST_TRAP);

    always_comb begin
        state_n  = state_q;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        iord     = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        regdst   = RD_RT;
        memtoreg = MR_ALU;
        alusrc_a = 1'b0;
        alusrc_b = SB_RT;
        alu_op   = ALU_ADD;
        ext_op   = EXT_SIGN;
        pc_src   = PC_ALU;
        if (rst_q) begin
            state_n = ST_FETCH;
        end else begin
            if (!(state_q inside {ST_FETCH, ST_DECODE, ST_TRAP}))
                ext_op = dec_q.ext_op;
            case (state_q)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    alusrc_b = SB_FOUR;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_n = ST_DECODE;
                    end else if (timeout) begin
                        state_n = ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    alusrc_b = SB_IMM4;
                    ext_op   = dec.ext_op;
                    if (illegal)
                        state_n = ST_TRAP;
                    else
                        case (dec.iclass)
                            CL_R:                 state_n = ST_EXEC_R;
                            CL_I:                 state_n = ST_EXEC_I;
                            CL_LW, CL_SW:         state_n = ST_MEM_ADDR;
                            CL_BEQ, CL_BNE:       state_n = ST_BRANCH;
                            CL_J, CL_JAL, CL_JR:  state_n = ST_JUMP;
                            default:              state_n = ST_TRAP;
                        endcase
                end
                ST_EXEC_R, ST_WB_R: begin
                    alusrc_a = 1'b1;
                    alu_op   = dec_q.alu_op;
                    regdst   = RD_RD;
                    reg_we   = (state_q == ST_WB_R);
                    state_n  = (state_q == ST_EXEC_R) ? ST_WB_R : ST_FETCH;
                end
                ST_EXEC_I, ST_WB_I: begin
                    alusrc_a = 1'b1;
                    alusrc_b = SB_IMM;
                    alu_op   = dec_q.alu_op;
                    reg_we   = (state_q == ST_WB_I);
                    state_n  = (state_q == ST_EXEC_I) ? ST_WB_I : ST_FETCH;
                end
                ST_MEM_ADDR: begin
                    alusrc_a = 1'b1;
                    alusrc_b = SB_IMM;
                    state_n  = (dec_q.iclass == CL_SW) ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD, ST_MEM_WR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (state_q == ST_MEM_WR);
                    if (mem_ready)
                        state_n = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
                    else if (timeout)
                        state_n = ST_TRAP;
                end
                ST_WB_MEM: begin
                    reg_we   = 1'b1;
                    memtoreg = MR_MDR;
                    state_n  = ST_FETCH;
                end
                ST_BRANCH: begin
                    alusrc_a = 1'b1;
                    alu_op   = ALU_SUB;
                    pc_src   = PC_OUT;
                    pc_we    = ((dec_q.iclass == CL_BEQ) && zero) ||
                               ((dec_q.iclass == CL_BNE) && !zero);
                    state_n  = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_we   = 1'b1;
                    pc_src  = (dec_q.iclass == CL_JR) ? PC_RS : PC_JUMP;
                    if (dec_q.iclass == CL_JAL) begin
                        reg_we   = 1'b1;
                        regdst   = RD_RA;
                        memtoreg = MR_PC;
                    end
                    state_n = ST_FETCH;
                end
                ST_TRAP: state_n = ST_TRAP;
                default: state_n = ST_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its state sequence and
// checks selects, handshake holding, retire counting, illegal-op and memory-timeout traps.
module tb_mc_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_we, ir_we, iord, mem_req, mem_we, reg_we, alusrc_a, trap;
    logic [1:0]  regdst, memtoreg, alusrc_b, ext_op, pc_src;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] instr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    mc_ctrl #(.MEM_TIMEOUT(255), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .iord      (iord),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .reg_we    (reg_we),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrc_a  (alusrc_a),
        .alusrc_b  (alusrc_b),
        .alu_op    (alu_op),
        .ext_op    (ext_op),
        .pc_src    (pc_src),
        .state     (state),
        .trap      (trap),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH; presents the instruction with mem_ready and leaves the FSM in DECODE.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input string tag);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        #1;
        check({tag, " fetch ir_we"}, 32'(ir_we), 1);
        check({tag, " fetch iord"}, 32'(iord), 0);
        step();
        check({tag, " decode state"}, 32'(state), 32'(ST_DECODE));
    endtask

    task automatic itype(input logic [5:0] op, input logic [1:0] ext, input int cnt, input string tag);
        fetch(op, 6'h00, tag);
        check({tag, " decode ext"}, 32'(ext_op), 32'(ext));
        step();
        check({tag, " exec state"}, 32'(state), 32'(ST_EXEC_I));
        check({tag, " exec ext"}, 32'(ext_op), 32'(ext));
        check({tag, " exec alusrc_b"}, 32'(alusrc_b), 2);
        check({tag, " exec regdst"}, 32'(regdst), 0);
        check({tag, " exec reg_we"}, 32'(reg_we), 0);
        step();
        check({tag, " wb state"}, 32'(state), 32'(ST_WB_I));
        check({tag, " wb reg_we"}, 32'(reg_we), 1);
        check({tag, " wb ext"}, 32'(ext_op), 32'(ext));
        step();
        check({tag, " retire state"}, 32'(state), 32'(ST_FETCH));
        check({tag, " retire reg_we"}, 32'(reg_we), 0);
        check({tag, " instr_cnt"}, instr_cnt, 32'(cnt));
    endtask

    initial begin
        // Reset: mem_ready high must be ignored, all outputs quiet.
        rst_n = 1'b0;
        mem_ready = 1'b1;
        step();
        step();
        check("rst state", 32'(state), 32'(ST_FETCH));
        check("rst instr_cnt", instr_cnt, 0);
        check("rst trap", 32'(trap), 0);
        check("rst mem_req", 32'(mem_req), 0);
        check("rst pc_we", 32'(pc_we), 0);
        check("rst alusrc_b", 32'(alusrc_b), 0);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        step();
        check("run mem_req", 32'(mem_req), 1);

        // I-type with each extension mode; mem_ready stays high throughout.
        itype(OP_ADDI, EXT_SIGN, 1, "addi");
        itype(OP_ORI,  EXT_ZERO, 2, "ori");
        itype(OP_LUI,  EXT_LUI,  3, "lui");

        // lw with memory ready delayed three cycles.
        fetch(OP_LW, 6'h00, "lw");
        step();
        check("lw addr state", 32'(state), 32'(ST_MEM_ADDR));
        check("lw addr alusrc_b", 32'(alusrc_b), 2);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw wait state", 32'(state), 32'(ST_MEM_RD));
            check("lw wait mem_req", 32'(mem_req), 1);
            check("lw wait iord", 32'(iord), 1);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check("lw ready mem_req", 32'(mem_req), 1);
        check("lw ready iord", 32'(iord), 1);
        step();
        check("lw wb state", 32'(state), 32'(ST_WB_MEM));
        check("lw wb memtoreg", 32'(memtoreg), 1);
        check("lw wb reg_we", 32'(reg_we), 1);
        step();
        check("lw instr_cnt", instr_cnt, 4);

        // beq / bne against both zero values within the BRANCH cycle.
        fetch(OP_BEQ, 6'h00, "beq");
        step();
        check("beq state", 32'(state), 32'(ST_BRANCH));
        zero = 1'b1;
        #1;
        check("beq z1 pc_we", 32'(pc_we), 1);
        check("beq pc_src", 32'(pc_src), 1);
        check("beq alu_op", 32'(alu_op), 1);
        zero = 1'b0;
        #1;
        check("beq z0 pc_we", 32'(pc_we), 0);
        step();
        check("beq instr_cnt", instr_cnt, 5);
        fetch(OP_BNE, 6'h00, "bne");
        step();
        zero = 1'b1;
        #1;
        check("bne z1 pc_we", 32'(pc_we), 0);
        zero = 1'b0;
        #1;
        check("bne z0 pc_we", 32'(pc_we), 1);
        check("bne pc_src", 32'(pc_src), 1);
        step();
        check("bne instr_cnt", instr_cnt, 6);

        // jal links $31 with PC; jr takes rs.
        fetch(OP_JAL, 6'h00, "jal");
        step();
        check("jal state", 32'(state), 32'(ST_JUMP));
        check("jal pc_we", 32'(pc_we), 1);
        check("jal pc_src", 32'(pc_src), 2);
        check("jal regdst", 32'(regdst), 2);
        check("jal memtoreg", 32'(memtoreg), 2);
        check("jal reg_we", 32'(reg_we), 1);
        step();
        check("jal instr_cnt", instr_cnt, 7);
        fetch(OP_RTYPE, FN_JR, "jr");
        step();
        check("jr pc_src", 32'(pc_src), 3);
        check("jr pc_we", 32'(pc_we), 1);
        check("jr reg_we", 32'(reg_we), 0);
        step();
        check("jr instr_cnt", instr_cnt, 8);

        // R-type sub.
        fetch(OP_RTYPE, FN_SUB, "sub");
        step();
        check("sub exec state", 32'(state), 32'(ST_EXEC_R));
        check("sub alu_op", 32'(alu_op), 1);
        check("sub regdst", 32'(regdst), 1);
        step();
        check("sub wb reg_we", 32'(reg_we), 1);
        check("sub wb regdst", 32'(regdst), 1);
        step();
        check("sub instr_cnt", instr_cnt, 9);

        // sw interrupted by reset while waiting in MEM_WR.
        fetch(OP_SW, 6'h00, "sw");
        step();
        mem_ready = 1'b0;
        step();
        check("sw state", 32'(state), 32'(ST_MEM_WR));
        check("sw mem_we", 32'(mem_we), 1);
        check("sw mem_req", 32'(mem_req), 1);
        rst_n = 1'b0;
        step();
        check("sw rst state", 32'(state), 32'(ST_FETCH));
        check("sw rst mem_req", 32'(mem_req), 0);
        check("sw rst pc_we", 32'(pc_we), 0);
        check("sw rst reg_we", 32'(reg_we), 0);
        check("sw rst instr_cnt", instr_cnt, 0);
        rst_n = 1'b1;
        step();

        // Illegal opcode traps and stays trapped.
        fetch(6'h3F, 6'h00, "ill op");
        step();
        check("ill op state", 32'(state), 32'(ST_TRAP));
        check("ill op trap", 32'(trap), 1);
        check("ill op mem_req", 32'(mem_req), 0);
        step();
        step();
        check("ill op sticky", 32'(state), 32'(ST_TRAP));
        check("ill op pc_we", 32'(pc_we), 0);
        rst_n = 1'b0;
        step();
        check("ill rst trap", 32'(trap), 0);
        rst_n = 1'b1;
        step();

        // Illegal funct under R-type.
        fetch(OP_RTYPE, 6'h3F, "ill fn");
        step();
        check("ill fn trap", 32'(trap), 1);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Memory timeout in FETCH: 254 waiting cycles survive, the 255th traps.
        repeat (254) step();
        check("tmo edge state", 32'(state), 32'(ST_FETCH));
        check("tmo edge trap", 32'(trap), 0);
        check("tmo edge mem_req", 32'(mem_req), 1);
        step();
        check("tmo state", 32'(state), 32'(ST_TRAP));
        check("tmo trap", 32'(trap), 1);
        check("tmo mem_req", 32'(mem_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
